// File: rtl/poly_key_synth.sv
// rtl/poly_key_synth.sv - polyphonic PS/2 key synthesizer with voice stealing and sigma-delta mix
//
// Purpose: parses the raw PS/2 scan-code byte stream, allocates the eight note
// keys to NUM_VOICES square-wave voices (lowest free voice first, round-robin
// steal when all are busy), and mixes the voices into a level and a 1-bit
// sigma-delta speaker stream.
//
// Ports:
//   i_clk            system clock (100 MHz)
//   i_reset          synchronous active-high reset
//   i_scan_valid     one-cycle strobe qualifying i_scan_code
//   i_scan_code      PS/2 scan-code byte
//   i_oct_sel        0/3 table pitch, 1 octave up, 2 octave down (latched at press)
//   i_panic          releases all voices; a same-cycle byte is dropped
//   o_voice_active   voice i holds a key
//   o_voice_wave     square output of voice i (0 when inactive)
//   o_mix_level      registered popcount of o_voice_wave
//   o_speaker        sigma-delta bitstream of o_mix_level / NUM_VOICES
module poly_key_synth #(
  parameter int NUM_VOICES = 4,
  parameter int CNT_W      = 20,
  parameter int LVL_W      = $clog2(NUM_VOICES + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_scan_valid,
  input  logic [7:0]            i_scan_code,
  input  logic [1:0]            i_oct_sel,
  input  logic                  i_panic,
  output logic [NUM_VOICES-1:0] o_voice_active,
  output logic [NUM_VOICES-1:0] o_voice_wave,
  output logic [LVL_W-1:0]      o_mix_level,
  output logic                  o_speaker
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACC_W = LVL_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_VOICES - 1);

  typedef enum logic {S_IDLE = 1'b0, S_BREAK = 1'b1} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_press;
  logic   w_release;

  logic [NUM_VOICES-1:0]            r_active;
  logic [NUM_VOICES-1:0]            r_wave;
  logic [NUM_VOICES-1:0][7:0]       r_key;
  logic [NUM_VOICES-1:0][CNT_W-1:0] r_half;
  logic [NUM_VOICES-1:0][CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0]                 r_steal_ptr;

  logic [LVL_W-1:0] r_mix;
  logic [ACC_W-1:0] r_acc;
  logic             r_speaker;

  // Parser state register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Parser next state and press/release decode; panic drops the byte
  always_comb begin
    w_state_nxt = r_state;
    w_press     = 1'b0;
    w_release   = 1'b0;
    if (i_panic) begin
      w_state_nxt = S_IDLE;
    end else if (i_scan_valid) begin
      case (i_scan_code)
        8'hE0: w_state_nxt = r_state;
        8'hF0: w_state_nxt = S_BREAK;
        default: begin
          if (r_state == S_BREAK) begin
            w_release   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_press = 1'b1;
          end
        end
      endcase
    end
  end

  // Half-period table, then octave shift selected at the press cycle
  logic             w_mapped;
  logic [CNT_W-1:0] w_tbl;
  logic [CNT_W-1:0] w_half_new;

  always_comb begin
    w_mapped = 1'b1;
    w_tbl    = '0;
    case (i_scan_code)
      8'h1C:   w_tbl = CNT_W'(191109);
      8'h1B:   w_tbl = CNT_W'(170265);
      8'h23:   w_tbl = CNT_W'(151685);
      8'h2B:   w_tbl = CNT_W'(143172);
      8'h34:   w_tbl = CNT_W'(127550);
      8'h33:   w_tbl = CNT_W'(113636);
      8'h3B:   w_tbl = CNT_W'(101238);
      8'h42:   w_tbl = CNT_W'(95556);
      default: w_mapped = 1'b0;
    endcase
    case (i_oct_sel)
      2'd1:    w_half_new = w_tbl >> 1;
      2'd2:    w_half_new = w_tbl << 1;
      default: w_half_new = w_tbl;
    endcase
  end

  // Key lookup among active voices and lowest-index free voice.
  // Iterating downward lets the lowest matching index win.
  logic             w_hit;
  logic [IDX_W-1:0] w_hit_idx;
  logic             w_free;
  logic [IDX_W-1:0] w_free_idx;

  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (r_active[i] && (r_key[i] == i_scan_code)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
      if (!r_active[i]) begin
        w_free     = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  logic             w_do_alloc;
  logic             w_do_rel;
  logic [IDX_W-1:0] w_alloc_idx;

  // A held key pressed again is typematic repeat and is ignored
  assign w_do_alloc  = w_press && w_mapped && !w_hit;
  assign w_do_rel    = w_release && w_mapped && w_hit;
  assign w_alloc_idx = w_free ? w_free_idx : r_steal_ptr;

  // Voice bank
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_active    <= '0;
      r_wave      <= '0;
      r_key       <= '0;
      r_half      <= '0;
      r_cnt       <= '0;
      r_steal_ptr <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (i_panic) begin
          r_active[i] <= 1'b0;
          r_wave[i]   <= 1'b0;
          r_cnt[i]    <= '0;
        end else if (w_do_alloc && (w_alloc_idx == IDX_W'(i))) begin
          r_active[i] <= 1'b1;
          r_key[i]    <= i_scan_code;
          r_half[i]   <= w_half_new;
          r_cnt[i]    <= '0;
          r_wave[i]   <= 1'b0;
        end else if (w_do_rel && (w_hit_idx == IDX_W'(i))) begin
          r_active[i] <= 1'b0;
          r_cnt[i]    <= '0;
          r_wave[i]   <= 1'b0;
        end else if (r_active[i]) begin
          if (r_cnt[i] == r_half[i] - CNT_ONE) begin
            r_cnt[i]  <= '0;
            r_wave[i] <= ~r_wave[i];
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_ONE;
          end
        end
      end
      if (i_panic) begin
        r_steal_ptr <= '0;
      end else if (w_do_alloc && !w_free) begin
        r_steal_ptr <= (r_steal_ptr == IDX_MAX) ? '0 : r_steal_ptr + IDX_ONE;
      end
    end
  end

  // Mix path: popcount, then first-order sigma-delta against NUM_VOICES
  logic [LVL_W-1:0] w_pop;
  logic [ACC_W-1:0] w_sum;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_pop = w_pop + LVL_W'(r_wave[i]);
    end
    w_sum = r_acc + ACC_W'(r_mix);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mix     <= '0;
      r_acc     <= '0;
      r_speaker <= 1'b0;
    end else begin
      r_mix <= w_pop;
      if (w_sum >= ACC_W'(NUM_VOICES)) begin
        r_acc     <= w_sum - ACC_W'(NUM_VOICES);
        r_speaker <= 1'b1;
      end else begin
        r_acc     <= w_sum;
        r_speaker <= 1'b0;
      end
    end
  end

  assign o_voice_active = r_active;
  assign o_voice_wave   = r_wave;
  assign o_mix_level    = r_mix;
  assign o_speaker      = r_speaker;

endmodule

// File: doc/poly_key_synth.md
# poly_key_synth

Polyphonic successor to the single-note keyboard synthesizer. Consumes the raw PS/2 scan-code byte stream, tracks make/break events for the eight note keys and allocates them to `NUM_VOICES` square-wave voices with voice stealing and octave shift. It mixes the active voices into a level and a 1-bit sigma-delta speaker stream. It sits between the PS/2 receiver and the speaker pin.

## Interface
- `NUM_VOICES`, default 4: number of simultaneous voices; minimum 1.
- `CNT_W`, default 20: half-period counter width; must be at least 19 so the octave-down values fit.
- `LVL_W`, default $clog2(NUM_VOICES+1): mix level width.
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: synchronous, active-high reset.
- `scan_valid` in 1: one-cycle strobe; `scan_code` is valid while high.
- `scan_code` in 8: one PS/2 scan-code byte.
- `oct_sel` in 2: 0 = table pitch; 1 = one octave up (half-period >>1); 2 = one octave down (<<1); 3 = same as 0.
- `panic` in 1: releases all voices.
- `voice_active` out NUM_VOICES: voice i is holding a key.
- `voice_wave` out NUM_VOICES: square output of voice i; 0 when inactive.
- `mix_level` out LVL_W: registered popcount of `voice_wave`.
- `speaker` out 1: sigma-delta bitstream of `mix_level`/NUM_VOICES.

## Operation
- **Half-period table** (clk cycles, 100 MHz):
  - 1C→C4 191109; 1B→D4 170265; 23→E4 151685; 2B→F4 143172
  - 34→G4 127550; 33→A4 113636; 3B→B4 101238; 42→C5 95556
  - All other codes are unmapped.
- **Byte parser**, states IDLE and BREAK:
  - E0 is discarded in any state; the state is unchanged.
  - F0 in IDLE moves to BREAK.
  - Any other byte in BREAK is a release of that code, then the parser returns to IDLE.
  - Any other byte in IDLE is a press.
  - F0 while already in BREAK stays in BREAK.
- **Press of a mapped key:**
  - Key already held by a voice (typematic repeat): ignored.
  - Otherwise: allocate the lowest-index inactive voice.
  - If all voices are active: steal the voice at `steal_ptr`, then advance `steal_ptr` modulo NUM_VOICES.
  - The allocated voice stores the key code and latches half-period = table value shifted by the `oct_sel` in effect that cycle. Later `oct_sel` changes do not retune held notes.
  - Its counter is cleared to 0 and its wave to 0.
- **Release of a mapped key:**
  - The voice holding that code is deactivated, with wave=0 and counter=0.
  - Release of a key held by no voice is ignored.
- **Unmapped press or release:** no effect beyond the parser state update.
- **Voice i, while active:**
  - When counter == half_period-1: counter←0 and wave toggles.
  - Otherwise: counter increments.
- **Mix path:**
  - `mix_level` ← popcount(`voice_wave`).
  - Accumulator `acc` is LVL_W+1 bits. If acc+mix_level ≥ NUM_VOICES: acc←acc+mix_level−NUM_VOICES and `speaker`←1. Otherwise: acc←acc+mix_level and `speaker`←0.
- **Panic:** all voices inactive, `steal_ptr`←0, parser←IDLE. A `scan_valid` in the same cycle is dropped.

## Timing
- **Reset:** all outputs 0; parser IDLE; `steal_ptr`, `acc`, all counters and key registers 0.
- **Reset mid-note:** silence in the next cycle.
- **Key event latency:** a byte strobed at edge t updates `voice_active` at t+1. The first wave toggle is at t+1+half_period.
- **Mix latency:** `mix_level` lags `voice_wave` by 1 cycle; `speaker` lags `mix_level` by 1 cycle.
- **Throughput:** one byte per cycle is accepted; back-to-back strobes are legal.
- **Same-cycle release and re-press:** not possible, since events are serialised by bytes.
- **Steal:** the stolen voice's old key is forgotten. A later break of that old key is ignored.
- **Full-scale mix:** `mix_level`==NUM_VOICES gives `speaker` constant 1. A level of 0 gives constant 0.

## Test plan
- Reset, then bytes 1C: `voice_active`=0001 one cycle later. `voice_wave[0]` rises 191109 cycles later and period is 382218. Then F0,1C: `voice_active`=0000 and wave 0.
- `oct_sel`=1, press 42: voice 0 half-period 47778. Change `oct_sel` to 2 while held: pitch unchanged. Release, then press 42 again: half-period 191112.
- Press 1C,1B,23,2B,34 (NUM_VOICES=4): the fifth key steals voice 0 and `steal_ptr`=1. Then F0,1C: no change. Then F0,34: voice 0 freed.
- Press 1C repeated three times (typematic): only voice 0 active. Press E0,1C: still one voice. Press 15 (unmapped): no change.
- Two voices held with waves both 1: `mix_level`=2 and `speaker` pattern 1010… for NUM_VOICES=4. All four waves 1: `speaker` constant 1.
- Three voices held; assert `panic` with `scan_valid`=1 and code 33 in the same cycle: all voices off, 33 not allocated, parser IDLE. Assert `reset` mid-note: all outputs 0 next cycle.
